// File: rtl/regfile_pkg.sv
// Shared types and constants for the sequenced register file (regfile_seq).
// Opcode and FSM encodings live here so the datapath, storage and bench agree.
package regfile_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'd0,
        OP_MOVE  = 3'd1,
        OP_READ  = 3'd2,
        OP_SWAP  = 3'd3,
        OP_CLEAR = 3'd4,
        OP_INC   = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWAP2 = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Instruction layout is {op, rd, rs}, MSB first.
    function automatic int instr_w(input int addr_w);
        return OP_W + 2 * addr_w;
    endfunction

endpackage

// File: rtl/regfile_array.sv
// Register storage: one write port, two combinational read ports.
// Define REGFILE_ZERO_REG_EN to hardwire R[0] to zero (writes dropped, reads 0).
module regfile_array
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
`ifdef REGFILE_ZERO_REG_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
`ifdef REGFILE_ZERO_REG_EN
        if (raddr_a == '0) begin
            rdata_a = '0;
        end
        if (raddr_b == '0) begin
            rdata_b = '0;
        end
`endif
    end

endmodule

// File: rtl/regfile_seq.sv
// Sequenced register file: valid/ready instruction port, 2-cycle SWAP, N-cycle CLEAR.
// Optional REGFILE_ZERO_REG_EN (handled in regfile_array) makes R[0] read-only zero.
module regfile_seq
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int INSTR_W  = OP_W + 2 * ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_out_valid,
    output logic               busy
);

    // Handshake: an instruction (instr + data_in) is taken on a rising edge where
    // instr_valid && instr_ready; instr_ready depends on state only (high in IDLE).
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    op_e               op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic              accept;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] temp_q, temp_d;
    logic [ADDR_W-1:0] swap_rd_q, swap_rd_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rd_data;

    assign op     = op_e'(instr[INSTR_W-1 -: OP_W]);
    assign rd     = instr[2*ADDR_W-1 -: ADDR_W];
    assign rs     = instr[ADDR_W-1:0];
    assign accept = instr_valid && instr_ready;

    regfile_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (rs),
        .rdata_a (rs_data),
        .raddr_b (rd),
        .rdata_b (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_SWAP) begin
                    state_d = ST_SWAP2;
                end else if (accept && op == OP_CLEAR) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SWAP2: state_d = ST_IDLE;
            ST_CLEAR: begin
                if (cnt_q == LAST_REG) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Single write port: the accept cycle and the SWAP2/CLEAR cycles never overlap.
    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        we          = 1'b0;
        waddr       = rd;
        wdata       = data_in;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            we    = 1'b1;
                            waddr = rd;
                            wdata = data_in;
                        end
                        OP_MOVE: begin
                            we    = 1'b1;
                            waddr = rd;
                            wdata = rs_data;
                        end
                        OP_SWAP: begin
                            we    = 1'b1;
                            waddr = rs;
                            wdata = rd_data;
                        end
                        OP_CLEAR: begin
                            we    = 1'b1;
                            waddr = '0;
                            wdata = '0;
                        end
                        OP_INC: begin
                            we    = 1'b1;
                            waddr = rd;
                            wdata = rs_data + DATA_W'(1);
                        end
                        default: we = 1'b0;
                    endcase
                end
            end
            ST_SWAP2: begin
                we    = 1'b1;
                waddr = swap_rd_q;
                wdata = temp_q;
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
            end
            default: we = 1'b0;
        endcase
    end

    always_comb begin
        temp_d           = temp_q;
        swap_rd_d        = swap_rd_q;
        cnt_d            = cnt_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        if (accept) begin
            case (op)
                OP_READ: begin
                    data_out_d       = rs_data;
                    data_out_valid_d = 1'b1;
                end
                OP_SWAP: begin
                    temp_d    = rs_data;
                    swap_rd_d = rd;
                end
                OP_CLEAR: cnt_d = ADDR_W'(1);
                default:  cnt_d = cnt_q;
            endcase
        end
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            temp_q           <= '0;
            swap_rd_q        <= '0;
            cnt_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            temp_q           <= temp_d;
            swap_rd_q        <= swap_rd_d;
            cnt_q            <= cnt_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

    a_valid_after_read: assert property (@(posedge clk) disable iff (!rst)
        data_out_valid |-> $past(accept && op == OP_READ));

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: directed scenarios plus random instruction stream
// against an instruction-level register model.
module tb_regfile_seq;
    import regfile_pkg::*;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 2;
    localparam int INSTR_W  = OP_W + 2 * ADDR_W;

    logic               clk = 1'b0;
    logic               rst;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [DATA_W-1:0]  data_in;
    logic [DATA_W-1:0]  data_out;
    logic               data_out_valid;
    logic               busy;

    always #5 clk = ~clk;

    regfile_seq #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy)
    );

    int                n_vec = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] mdl_r [NUM_REGS];
    logic [DATA_W-1:0] mdl_dout;
    logic [DATA_W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mdl_read(input int a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        return mdl_r[a];
    endfunction

    function automatic void mdl_write(input int a, input logic [DATA_W-1:0] v);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return;
`endif
        mdl_r[a] = v;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < NUM_REGS; i++) mdl_r[i] = '0;
        mdl_dout = '0;
    endfunction

    // Presents one instruction from a negedge and returns at the negedge after its accept.
    task automatic send(input op_e op, input int rd, input int rs, input logic [DATA_W-1:0] din);
        int budget = 40;
        logic [ADDR_W-1:0] rd_v = ADDR_W'(rd);
        logic [ADDR_W-1:0] rs_v = ADDR_W'(rs);
        instr       = {op, rd_v, rs_v};
        data_in     = din;
        instr_valid = 1'b1;
        while (!instr_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!instr_ready) check_eq("accept_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = INSTR_W'($urandom);
        data_in     = DATA_W'($urandom);
    endtask

    task automatic exec(input op_e op, input int rd, input int rs, input logic [DATA_W-1:0] din);
        logic [DATA_W-1:0] tmp;
        send(op, rd, rs, din);
        case (op)
            OP_READ: begin
                exp_q.push_back(mdl_read(rs));
                mdl_dout = mdl_read(rs);
                check_eq("read_valid", 32'(data_out_valid), 32'd1);
                check_eq("read_data", 32'(data_out), 32'(exp_q.pop_front()));
                @(negedge clk);
                check_eq("read_valid_drop", 32'(data_out_valid), 32'd0);
                check_eq("read_hold", 32'(data_out), 32'(mdl_dout));
            end
            OP_SWAP: begin
                tmp = mdl_read(rs);
                mdl_write(rs, mdl_read(rd));
                mdl_write(rd, tmp);
                check_eq("swap_busy", 32'(busy), 32'd1);
                check_eq("swap_ready_low", 32'(instr_ready), 32'd0);
                @(negedge clk);
                check_eq("swap_busy_end", 32'(busy), 32'd0);
                check_eq("swap_ready_back", 32'(instr_ready), 32'd1);
            end
            OP_CLEAR: begin
                for (int i = 0; i < NUM_REGS; i++) mdl_r[i] = '0;
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    check_eq("clear_busy", 32'(busy), 32'd1);
                    @(negedge clk);
                end
                check_eq("clear_busy_end", 32'(busy), 32'd0);
                check_eq("clear_ready_back", 32'(instr_ready), 32'd1);
            end
            default: begin
                if (op == OP_LOAD) mdl_write(rd, din);
                if (op == OP_MOVE) mdl_write(rd, mdl_read(rs));
                if (op == OP_INC)  mdl_write(rd, mdl_read(rs) + 8'd1);
                check_eq("single_busy", 32'(busy), 32'd0);
                check_eq("single_no_valid", 32'(data_out_valid), 32'd0);
                check_eq("single_dout_hold", 32'(data_out), 32'(mdl_dout));
            end
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b0;
            instr       = INSTR_W'($urandom);
            data_in     = DATA_W'($urandom);
            @(negedge clk);
            check_eq("idle_no_valid", 32'(data_out_valid), 32'd0);
            check_eq("idle_dout_hold", 32'(data_out), 32'(mdl_dout));
        end
    endtask

    task automatic check_all();
        for (int a = 0; a < NUM_REGS; a++) exec(OP_READ, 0, a, 8'h00);
    endtask

    initial begin
        int waits;
        int r;
        op_e op;

        rst         = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        data_in     = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_dout", 32'(data_out), 32'd0);
        check_eq("rst_dout_valid", 32'(data_out_valid), 32'd0);
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        check_all();

        // LOAD then READ of the same register on the very next cycle
        exec(OP_LOAD, 2, 0, 8'hA5);
        exec(OP_READ, 0, 2, 8'h00);
        check_eq("b2b_const", 32'(data_out), 32'hA5);

        exec(OP_LOAD, 1, 0, 8'h11);
        exec(OP_LOAD, 3, 0, 8'h33);
        exec(OP_SWAP, 1, 3, 8'h00);
        exec(OP_READ, 0, 1, 8'h00);
        check_eq("swap_r1_const", 32'(data_out), 32'h33);
        exec(OP_READ, 0, 3, 8'h00);
        check_eq("swap_r3_const", 32'(data_out), 32'h11);
        exec(OP_LOAD, 2, 0, 8'h5C);
        exec(OP_SWAP, 2, 2, 8'h00);
        exec(OP_READ, 0, 2, 8'h00);
        check_eq("swap_same_const", 32'(data_out), 32'h5C);

        // CLEAR with a LOAD waiting behind it on a held-high valid
        for (int a = 0; a < NUM_REGS; a++) exec(OP_LOAD, a, 0, 8'(8'h81 + a));
        send(OP_CLEAR, 0, 0, 8'h00);
        for (int i = 0; i < NUM_REGS; i++) mdl_r[i] = '0;
        instr       = {OP_LOAD, 2'd1, 2'd0};
        data_in     = 8'h77;
        instr_valid = 1'b1;
        waits       = 0;
        while (!instr_ready && waits < 20) begin
            check_eq("clear_hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
            waits++;
        end
        check_eq("clear_wait_cycles", 32'(waits), 32'd3);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        mdl_write(1, 8'h77);
        check_all();
        exec(OP_READ, 0, 1, 8'h00);
        check_eq("clear_load_lands", 32'(data_out), 32'h77);
        exec(OP_READ, 0, 3, 8'h00);
        check_eq("clear_r3_zero", 32'(data_out), 32'h00);

        exec(OP_LOAD, 0, 0, 8'hFF);
        exec(OP_INC, 1, 0, 8'h00);
        exec(OP_READ, 0, 1, 8'h00);
`ifdef REGFILE_ZERO_REG_EN
        check_eq("inc_wrap_const", 32'(data_out), 32'h01);
`else
        check_eq("inc_wrap_const", 32'(data_out), 32'h00);
`endif
        exec(OP_LOAD, 0, 0, 8'h7F);
        exec(OP_READ, 0, 0, 8'h00);
`ifdef REGFILE_ZERO_REG_EN
        check_eq("r0_const", 32'(data_out), 32'h00);
`else
        check_eq("r0_const", 32'(data_out), 32'h7F);
`endif

        // Reset one cycle into a CLEAR sweep
        exec(OP_LOAD, 3, 0, 8'h5A);
        send(OP_CLEAR, 0, 0, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_dout", 32'(data_out), 32'd0);
        rst = 1'b1;
        mdl_reset();
        check_all();
        exec(OP_READ, 0, 3, 8'h00);
        check_eq("rst_mid_r3", 32'(data_out), 32'h00);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) op = OP_CLEAR;
            else begin
                op = op_e'(3'($urandom_range(0, 7)));
                if (op == OP_CLEAR) op = OP_READ;
            end
            exec(op, int'($urandom_range(0, NUM_REGS - 1)), int'($urandom_range(0, NUM_REGS - 1)),
                 DATA_W'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Parametrised successor to the prototype processor's two-entry register file.
- N registers of configurable width, driven by a 3-bit opcode plus register addresses, accepted through a valid/ready handshake.
- Adds multi-cycle operations:
  - SWAP: 2 cycles, through a temp register.
  - CLEAR: sweeps every register, one per cycle.
- Sits between the instruction decoder and the ALU/output path of the processor.

Parameters:
- DATA_W, 8, register and data bus width in bits (>=2).
- NUM_REGS, 4, number of registers; power of two, >=2.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- instr  in  3+2*ADDR_W  {op[2:0], rd[ADDR_W-1:0], rs[ADDR_W-1:0]}, MSB first.
- instr_valid  in  1  instr and data_in are valid this cycle.
- instr_ready  out  1  block can accept an instruction this cycle.
- data_in  in  DATA_W  write data for LOAD.
- data_out  out  DATA_W  read result; holds until the next READ or reset.
- data_out_valid  out  1  one-cycle pulse when data_out is updated.
- busy  out  1  high while in SWAP2 or CLEAR.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All registers, temp, the sweep counter, data_out and data_out_valid go to 0; state goes to IDLE.
  - Reset aborts any SWAP or CLEAR in progress.
- Handshake:
  - An instruction is accepted on an edge where instr_valid && instr_ready.
  - instr_ready = (state==IDLE); it is combinational from state only, with no dependence on instr_valid.
  - Nothing is sampled when there is no accept.
- Opcodes (writes become visible the cycle after accept):
  - 0 LOAD: R[rd] <= data_in.
  - 1 MOVE: R[rd] <= R[rs]. rd==rs is a no-op write.
  - 2 READ: data_out <= R[rs]; data_out_valid=1 for the following cycle. Latency 1.
  - 3 SWAP:
    - Accept cycle: temp <= R[rs], R[rs] <= R[rd], state -> SWAP2.
    - SWAP2 cycle: R[rd] <= temp, state -> IDLE.
    - rd==rs leaves the register unchanged.
    - Total 2 cycles; instr_ready is low during SWAP2.
  - 4 CLEAR:
    - Accept cycle: R[0] <= 0, cnt <= 1, state -> CLEAR.
    - Each CLEAR cycle: R[cnt] <= 0, cnt++.
    - When cnt==NUM_REGS-1 the write completes and state -> IDLE.
    - Total NUM_REGS cycles.
  - 5 INC: R[rd] <= R[rs]+1, modulo 2^DATA_W. All-ones wraps to 0; no carry out.
  - 6, 7: NOP, but still accepted (ready stays high).
- State machine: IDLE, SWAP2, CLEAR. Only IDLE accepts instructions.
- Back-to-back: a READ in the cycle after a LOAD to the same register returns the new value (the write is already committed).
- busy = (state != IDLE).
- data_out_valid is deasserted every cycle except the one after a READ accept.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - R[0] is hardwired to 0; writes to R[0] by LOAD, MOVE, INC and SWAP are discarded.
  - Reads of R[0] return 0.
  - CLEAR still takes NUM_REGS cycles.
- Undefined: R[0] is an ordinary register.

Decomposition:
- Shared package regfile_pkg holds:
  - Opcode enum: OP_LOAD=0, OP_MOVE=1, OP_READ=2, OP_SWAP=3, OP_CLEAR=4, OP_INC=5, OP_NOP6=6, OP_NOP7=7.
  - State enum: ST_IDLE, ST_SWAP2, ST_CLEAR.
  - Instruction field width constants.
- One sub-module, regfile_array: storage with one write port and two combinational read ports (rs, rd). The optional feature is gated there.
- FSM, handshake and sweep counter stay in regfile_seq.

Test Plan (all with DATA_W=8, NUM_REGS=4):
- Reset: rst=0 for 2 cycles, then READ R0..R3 -> data_out=0x00 each, data_out_valid one pulse per READ; instr_ready=1, busy=0.
- LOAD/READ back-to-back: LOAD R2 with 0xA5, then READ R2 next cycle -> data_out=0xA5 one cycle after the READ accept.
- SWAP: R1=0x11, R3=0x33; SWAP rd=1 rs=3 -> instr_ready low for exactly 1 cycle; then R1=0x33, R3=0x11. SWAP rd=rs=2 -> R2 unchanged.
- CLEAR mid-use: load all registers nonzero; CLEAR with instr_valid held high and a LOAD presented -> busy high 3 cycles after accept, the LOAD is not accepted until ready returns, all registers read 0x00, then the LOAD lands.
- INC wrap: R0=0xFF, INC rd=1 rs=0 -> R1=0x00. Repeat with REGFILE_ZERO_REG_EN and LOAD R0 0x7F -> READ R0 = 0x00.
- Reset mid-CLEAR: load R3=0x5A, issue CLEAR, assert rst after 1 cycle -> next cycle state IDLE, instr_ready=1, all registers 0x00.
